// File: rtl/mux_n_arb_pkg.sv
//------------------------------------------------------------------------------
// Module : mux_pkg
// Brief  : Shared mode and state encodings for the mux_n_arb operand selector.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ARB = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_n_arb_if.sv
//------------------------------------------------------------------------------
// Module : mux_n_arb_if
// Brief  : Select/handshake bundle between operand sources and the mux_n_arb block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_n_arb_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

endinterface

`default_nettype wire

// File: rtl/mux_n_arb_rr.sv
//------------------------------------------------------------------------------
// Module : mux_arb_rr
// Brief  : Request vector to one-hot grant. Round-robin from ptr when MUX_RR_EN
//          is defined, otherwise fixed priority with channel 0 highest.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_arb_rr #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
`ifdef MUX_RR_EN
  input  logic [SEL_W-1:0]    ptr,
`endif
  output logic [CHANNELS-1:0] gnt,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      int c;
`ifdef MUX_RR_EN
      // ptr is always a legal index, so the wrap needs only one modulo
      c = (int'(ptr) + k) % CHANNELS;
`else
      c = k;
`endif
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = SEL_W'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_arb.sv
//------------------------------------------------------------------------------
// Module : mux_n_arb
// Brief  : N:1 operand mux with one-entry registered output and valid/ready
//          handshake. Define MUX_RR_EN for round-robin arbitration in MODE_ARB.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_n_arb
  import mux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_n_arb_if.slave  bus
);

  localparam int SEL_W = $clog2(CHANNELS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic                w_load_ok;
  logic                w_xfer;
  logic                w_sel_hit;
  logic [CHANNELS-1:0] w_arb_gnt;
  logic [SEL_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [CHANNELS-1:0] w_gnt_vec;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_gnt_any;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0]    r_ptr;
`endif

  mux_arb_rr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req (bus.in_valid),
`ifdef MUX_RR_EN
    .ptr (r_ptr),
`endif
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  // Grant source: explicit select or arbiter
  always_comb begin
    w_sel_hit = (int'(bus.sel) < CHANNELS) && bus.in_valid[bus.sel];
    w_gnt_vec = '0;
    w_gnt_idx = bus.sel;
    w_gnt_any = w_sel_hit;
    if (bus.mode == MODE_ARB) begin
      w_gnt_vec = w_arb_gnt;
      w_gnt_idx = w_arb_idx;
      w_gnt_any = w_arb_any;
    end else if (w_sel_hit) begin
      w_gnt_vec = CHANNELS'(1) << bus.sel;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_load_ok     = (r_state == ST_EMPTY) || bus.out_ready;
    w_xfer        = w_load_ok && w_gnt_any;
    bus.in_ready  = w_load_ok ? w_gnt_vec : '0;
    bus.out_valid = (r_state == ST_FULL);
    if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if (w_load_ok) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_chan <= '0;
    end else if (w_xfer) begin
      r_data <= bus.in_data[w_gnt_idx*WIDTH +: WIDTH];
      r_chan <= w_gnt_idx;
    end
  end

`ifdef MUX_RR_EN
  // Pointer holds the next search start; only arbitrated transfers move it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer && (bus.mode == MODE_ARB)) begin
      r_ptr <= (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`endif

  assign bus.out_data = r_data;
  assign bus.out_chan = r_chan;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_arb.sv
//------------------------------------------------------------------------------
// Module : tb_mux_n_arb
// Brief  : Directed self-checking bench for mux_n_arb (WIDTH=16, CHANNELS=4).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_n_arb;
  import mux_pkg::*;

  logic        clk;
  logic        rst;
  int          checks;
  int          errors;
  logic [15:0] data [4];
  logic [17:0] sb_q [$];
  logic        m_full;
  logic [15:0] m_data;
  logic [1:0]  m_chan;

  mux_n_arb_if #(.WIDTH(16), .CHANNELS(4)) bus ();

  mux_n_arb #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_full));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".out_chan"},  32'(bus.out_chan),  32'(m_chan));
  endtask

  // One cycle: drive, check in_ready, push expected word, clock, pop and compare.
  task automatic step(input logic md, input logic [1:0] s, input logic [3:0] v,
                      input logic ordy, input logic [3:0] exp_rdy, input string tag);
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    bus.in_data   = {data[3], data[2], data[1], data[0]};
    #2;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) sb_q.push_back({2'(i), data[i]});
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      {m_chan, m_data} = sb_q.pop_front();
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    check_out(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_full = 1'b0;
    m_data = '0;
    m_chan = '0;
    data[0] = 16'hA000;
    data[1] = 16'hB001;
    data[2] = 16'd5;
    data[3] = 16'hC003;
    rst           = 1'b1;
    bus.mode      = MODE_SEL;
    bus.sel       = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset");

    // Explicit select, then select of an idle channel lets the register drain
    step(MODE_SEL, 2'd2, 4'b0110, 1'b1, 4'b0100, "sel2");
    step(MODE_SEL, 2'd3, 4'b0110, 1'b1, 4'b0000, "sel3_idle");
    step(MODE_SEL, 2'd3, 4'b0000, 1'b0, 4'b0000, "empty_hold");

    // Backpressure then drain-and-reload in the same cycle
    step(MODE_SEL, 2'd1, 4'b1111, 1'b1, 4'b0010, "bp_load");
    step(MODE_SEL, 2'd0, 4'b1111, 1'b0, 4'b0000, "bp_hold0");
    step(MODE_SEL, 2'd0, 4'b1111, 1'b0, 4'b0000, "bp_hold1");
    step(MODE_SEL, 2'd0, 4'b1111, 1'b0, 4'b0000, "bp_hold2");
    step(MODE_SEL, 2'd0, 4'b1111, 1'b1, 4'b0001, "bp_reload");

    // Mode switch while stalled leaves the held word untouched
    data[0] = 16'h1234;
    step(MODE_ARB, 2'd3, 4'b1111, 1'b0, 4'b0000, "sw_hold0");
    step(MODE_ARB, 2'd3, 4'b1111, 1'b0, 4'b0000, "sw_hold1");
    step(MODE_ARB, 2'd3, 4'b1111, 1'b1, 4'b0001, "sw_drain");

    // Asynchronous reset in the middle of a cycle while FULL
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_full = 1'b0;
    m_data = '0;
    m_chan = '0;
    check_out("async_rst");
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("post_rst");
    data[0] = 16'hA000;

`ifdef MUX_RR_EN
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr0");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr1");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0100, "rr2");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b1000, "rr3");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr4");
    // A select transfer must not move the pointer
    step(MODE_SEL, 2'd2, 4'b1111, 1'b1, 4'b0100, "rr_sel");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_after_sel");
`else
    step(MODE_ARB, 2'd0, 4'b1010, 1'b1, 4'b0010, "fix0");
    step(MODE_ARB, 2'd0, 4'b1010, 1'b1, 4'b0010, "fix1");
    step(MODE_ARB, 2'd0, 4'b1010, 1'b1, 4'b0010, "fix2");
    step(MODE_ARB, 2'd0, 4'b1000, 1'b1, 4'b1000, "fix3");
    step(MODE_ARB, 2'd0, 4'b1111, 1'b1, 4'b0001, "fix_all");
`endif

    // Final drain to EMPTY with last word still visible
    step(MODE_ARB, 2'd0, 4'b0000, 1'b1, 4'b0000, "drain");
    step(MODE_ARB, 2'd0, 4'b0000, 1'b0, 4'b0000, "idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
